// File: rtl/poly_eval_pipe_if.sv
`default_nettype none
// ============================================================================
// Module   : poly_eval_pipe_if
// Brief    : Operand/result handshake bundle for poly_eval_pipe.
// Revision : 1.0 - initial release
// ============================================================================
interface poly_eval_pipe_if #(
    parameter int WIDTH = 16,
    parameter int TAG_W = 4
) ();
    logic                    in_val;
    logic                    in_rdy;
    logic signed [WIDTH-1:0] a;
    logic signed [WIDTH-1:0] b;
    logic signed [WIDTH-1:0] c;
    logic signed [WIDTH-1:0] d;
    logic [TAG_W-1:0]        in_tag;
    logic                    out_val;
    logic                    out_rdy;
    logic signed [WIDTH-1:0] Q;
    logic [TAG_W-1:0]        out_tag;
    logic                    ovf;

    modport master (
        output in_val, a, b, c, d, in_tag, out_rdy,
        input  in_rdy, out_val, Q, out_tag, ovf
    );

    modport slave (
        input  in_val, a, b, c, d, in_tag, out_rdy,
        output in_rdy, out_val, Q, out_tag, ovf
    );
endinterface
`default_nettype wire

// File: rtl/poly_eval_pipe.sv
`default_nettype none
// ============================================================================
// Module   : poly_eval_pipe
// Brief    : 3-stage Q = ((a-b)*(1+3c) - 4d) >>> 1 with valid/ready flow.
//            Define POLY_EVAL_SAT_EN to clamp Q and report ovf.
// Revision : 1.0 - initial release
// ============================================================================
module poly_eval_pipe #(
    parameter int WIDTH = 16,
    parameter int TAG_W = 4
) (
    input  wire logic        clk,
    input  wire logic        rst,
    poly_eval_pipe_if.slave  bus
);
    localparam int c_iw = 2 * WIDTH + 5;
    localparam logic signed [WIDTH+2:0] c_k_one = (WIDTH+3)'(1);

    // Stage valids and advance enables; a stage advances when empty or
    // when everything below it can move.
    logic r_v1, r_v2, r_v3;
    logic w_adv1, w_adv2, w_adv3;
    logic w_ld1, w_ld2, w_ld3;

    assign w_adv3 = !r_v3 || bus.out_rdy;
    assign w_adv2 = !r_v2 || w_adv3;
    assign w_adv1 = !r_v1 || w_adv2;
    assign w_ld1  = w_adv1 && bus.in_val;
    assign w_ld2  = w_adv2 && r_v1;
    assign w_ld3  = w_adv3 && r_v2;

    assign bus.in_rdy = w_adv1;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_v1 <= 1'b0;
            r_v2 <= 1'b0;
            r_v3 <= 1'b0;
        end else begin
            if (w_adv1) r_v1 <= bus.in_val;
            if (w_adv2) r_v2 <= r_v1;
            if (w_adv3) r_v3 <= r_v2;
        end
    end

    // ---------------- Stage 1 ----------------
    logic signed [WIDTH:0]   w_diff, r_diff;
    logic signed [WIDTH+2:0] w_cx, w_k, r_k;
    logic signed [WIDTH+1:0] w_d4, r_d4_1;
    logic [TAG_W-1:0]        r_tag1;

    assign w_diff = (WIDTH+1)'(bus.a) - (WIDTH+1)'(bus.b);
    assign w_cx   = (WIDTH+3)'(bus.c);
    assign w_k    = w_cx + (w_cx <<< 1) + c_k_one;
    assign w_d4   = {bus.d, 2'b00};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_diff <= '0;
            r_k    <= '0;
            r_d4_1 <= '0;
            r_tag1 <= '0;
        end else if (w_ld1) begin
            r_diff <= w_diff;
            r_k    <= w_k;
            r_d4_1 <= w_d4;
            r_tag1 <= bus.in_tag;
        end
    end

    // ---------------- Stage 2 ----------------
    logic signed [c_iw-1:0]  w_prod, r_prod;
    logic signed [WIDTH+1:0] r_d4_2;
    logic [TAG_W-1:0]        r_tag2;

    assign w_prod = c_iw'(r_diff) * c_iw'(r_k);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_prod <= '0;
            r_d4_2 <= '0;
            r_tag2 <= '0;
        end else if (w_ld2) begin
            r_prod <= w_prod;
            r_d4_2 <= r_d4_1;
            r_tag2 <= r_tag1;
        end
    end

    // ---------------- Stage 3 ----------------
    logic signed [c_iw-1:0]  w_sub, w_r;
    logic signed [WIDTH-1:0] w_q, r_q;
    logic [TAG_W-1:0]        r_tag3;
    logic                    w_unused;

    assign w_sub = r_prod - c_iw'(r_d4_2);
    assign w_r   = w_sub >>> 1;

`ifdef POLY_EVAL_SAT_EN
    localparam logic signed [c_iw-1:0] c_qmax = {{(c_iw-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
    localparam logic signed [c_iw-1:0] c_qmin = {{(c_iw-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};
    logic w_ovf, r_ovf;

    always_comb begin
        w_q   = w_r[WIDTH-1:0];
        w_ovf = 1'b0;
        if (w_r > c_qmax) begin
            w_q   = c_qmax[WIDTH-1:0];
            w_ovf = 1'b1;
        end else if (w_r < c_qmin) begin
            w_q   = c_qmin[WIDTH-1:0];
            w_ovf = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst)        r_ovf <= 1'b0;
        else if (w_ld3) r_ovf <= w_ovf;
    end

    assign bus.ovf  = r_ovf;
    assign w_unused = w_sub[0];
`else
    assign w_q      = w_r[WIDTH-1:0];
    assign bus.ovf  = 1'b0;
    assign w_unused = ^{w_sub[0], w_r[c_iw-1:WIDTH]};
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_q    <= '0;
            r_tag3 <= '0;
        end else if (w_ld3) begin
            r_q    <= w_q;
            r_tag3 <= r_tag2;
        end
    end

    assign bus.out_val = r_v3;
    assign bus.Q       = r_q;
    assign bus.out_tag = r_tag3;
endmodule
`default_nettype wire

// File: doc/poly_eval_pipe.md
Name: poly_eval_pipe

Overview:
- Pipelined successor to the single-cycle polynomial evaluator. Computes Q = ((a - b) * (1 + 3c) - 4d) >>> 1 on signed operands.
- Three register stages with full valid/ready backpressure, a pass-through tag and optional saturation.
- Sits between an upstream operand producer and a downstream consumer that may stall.

Parameters:
- WIDTH, 16, signed operand and result width (>= 4).
- TAG_W, 4, width of the sideband tag carried with each operand set (>= 1).

Ports:
- clk  input  1  clock, all state on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_val  input  1  operand set valid.
- in_rdy  output  1  block can accept an operand set this cycle.
- a  input  WIDTH  signed operand.
- b  input  WIDTH  signed operand.
- c  input  WIDTH  signed operand.
- d  input  WIDTH  signed operand.
- in_tag  input  TAG_W  sideband tag, returned unchanged with the result.
- out_val  output  1  result valid.
- out_rdy  input  1  consumer accepts the result.
- Q  output  WIDTH  signed result.
- out_tag  output  TAG_W  tag of the current result.
- ovf  output  1  result did not fit in WIDTH (only with SAT_EN, else constant 0).

Behaviour:
- Interface: one clock clk; synchronous active-high reset rst. The clock and reset polarity/synchronicity are fixed.
- Handshake: a transfer occurs when val && rdy on the same edge, on both input and output. Once out_val is high, Q, out_tag and ovf stay stable until the result is accepted.
- Arithmetic is exact, with no intermediate overflow. Internal width is IW = 2*WIDTH+5.
  - S1 registers: diff = a - b (WIDTH+1 bits), k = 1 + 3*c (WIDTH+3 bits), d4 = 4*d (WIDTH+2 bits), tag, v1.
  - S2 registers: prod = diff * k (sign-extended to IW), d4, tag, v2.
  - S3 registers: r = (prod - d4) >>> 1, an arithmetic shift (floor toward -inf). Q = r[WIDTH-1:0] (truncation). Also registers tag and v3, which drives out_val.
- Pipeline advance: stage n loads when its valid is 0 or stage n+1 loads or drains. S3 drains when out_rdy = 1.
  - in_rdy = !v1 || S2 loads. This is combinational from out_rdy through the valid chain; there is no combinational path from in_val.
  - Bubbles collapse: a stalled head does not block empty downstream slots.
- Latency: 3 cycles from input acceptance to out_val with no stall. Throughput is 1 per cycle while out_rdy = 1.
- Capacity: 3 results in flight. With out_rdy held 0, in_rdy falls after the 3rd accepted set. There is no loss, duplication or reordering.
- Simultaneous events: when S3 drains and S2 loads on the same edge, the new value replaces the drained one and out_val stays 1.
- Reset: v1, v2 and v3 clear to 0; Q = 0, out_tag = 0, ovf = 0, out_val = 0.
  - rst asserted mid-stream discards all in-flight data on that edge.
  - in_rdy is 1 in the first cycle after reset release.
- Data registers never load while their stage valid is 0 and the stage is not loading. This is a power rule, not a functional one.

Optional Feature:
- Macro: POLY_EVAL_SAT_EN.
- Defined: S3 clamps r to [-2^(WIDTH-1), 2^(WIDTH-1)-1]. ovf is registered with the result and is 1 when clamping occurred, 0 otherwise.
- Undefined: Q is the low WIDTH bits of r (wrap-around) and ovf is tied to 0. No saturation logic is instantiated.

Test Plan:
- Basic, WIDTH=16, out_rdy=1: a=5, b=2, c=1, d=1, tag=3 -> out_val exactly 3 cycles later with Q=4, out_tag=3, ovf=0.
- Sign and rounding:
  - a=2, b=5, c=1, d=0 -> Q=-6.
  - a=1, b=0, c=0, d=0 -> Q=0.
  - a=0, b=1, c=0, d=0 -> Q=-1 (floor).
  - Issue these back-to-back: 3 results on consecutive cycles.
- Overflow: a=32767, b=-32768, c=32767, d=0.
  - Without macro: Q=16385 (0x4001), ovf=0.
  - With POLY_EVAL_SAT_EN: Q=32767, ovf=1.
  - Also a=-32768, b=32767, c=32767, d=0 with macro -> Q=-32768, ovf=1.
- Backpressure: stream tags 0..7 with in_val=1 and out_rdy=0 for 10 cycles.
  - in_rdy drops after tags 0..2 are accepted; Q/out_tag hold tag 0.
  - Release out_rdy: tags 0..7 emerge in order, one per cycle, none dropped.
- Random out_rdy (50%) and in_val (50%), 10k sets, checked against a reference model -> all results match in order; out_val never drops without a transfer.
- Reset mid-stream: 2 sets in flight, pulse rst for 1 cycle -> next cycle out_val=0, Q=0, in_rdy=1. The in-flight sets never appear; the next accepted set produces a correct result after 3 cycles.
